// File: rtl/rram_seq_ctrl_if.sv
// RRAM sequencer host/array bundle: request handshake, status, and serial array pins.
// Latency: none, wires only.
// Backpressure: busy tells the host when requests are being dropped.
interface rram_seq_ctrl_if #(
  parameter int BITS = 32
);
  logic            form_req;
  logic            wr_req;
  logic            rd_req;
  logic [4:0]      addr;
  logic [BITS-1:0] wdata;
  logic            busy;
  logic            done;
  logic            err;
  logic [BITS-1:0] rdata;
  logic            rram_ce;
  logic            rram_we;
  logic            rram_re;
  logic [4:0]      rram_addr;
  logic            rram_dout;
  logic            rram_oe;
  logic            rram_din;

  modport slave (
    input  form_req, wr_req, rd_req, addr, wdata, rram_din,
    output busy, done, err, rdata,
    output rram_ce, rram_we, rram_re, rram_addr, rram_dout, rram_oe
  );

  modport master (
    output form_req, wr_req, rd_req, addr, wdata, rram_din,
    input  busy, done, err, rdata,
    input  rram_ce, rram_we, rram_re, rram_addr, rram_dout, rram_oe
  );
endinterface

// File: rtl/rram_seq_ctrl.sv
// RRAM sequencer: forming pulse, serial word write and serial word read, gated by a formed-cell bitmap.
// Latency: done in the cycle after edge E0+SETUP_CYC+N (N=FORM_CYC or BITS); access to unformed cell fails in one cycle.
// Backpressure: none queued; requests seen while busy are dropped, only IDLE samples them.
module rram_seq_ctrl #(
  parameter int SETUP_CYC = 2,
  parameter int FORM_CYC  = 8,
  parameter int BITS      = 32
) (
  input logic           clk,
  input logic           CE,
  rram_seq_ctrl_if.slave bus
);

  localparam int CW   = $clog2(BITS) + 1;
  localparam int TMAX = (SETUP_CYC > FORM_CYC) ? SETUP_CYC : FORM_CYC;
  localparam int TW   = $clog2(TMAX + 1);

  typedef enum logic [2:0] {IDLE, SETUP, FORM, WSHIFT, RSHIFT, DONE} state_t;
  typedef enum logic [1:0] {OP_FORM, OP_WR, OP_RD} op_t;

  state_t          r_state;
  op_t             r_op;
  logic [31:0]     r_formed;
  logic [4:0]      r_addr;
  logic [BITS-1:0] r_wsh;
  logic [BITS-1:0] r_shadow;
  logic [BITS-1:0] r_rdata;
  logic [CW-1:0]   r_bit_cnt;
  logic [TW-1:0]   r_tmr;
  logic            r_busy, r_done, r_err;
  logic            r_ce, r_we, r_re, r_oe, r_dout;

  op_t  w_op;
  logic w_any_req;
  logic w_unformed;

  // Resolve request priority: forming beats write beats read.
  always_comb begin
    w_op = OP_RD;
    if (bus.form_req)    w_op = OP_FORM;
    else if (bus.wr_req) w_op = OP_WR;
  end

  assign w_any_req  = bus.form_req | bus.wr_req | bus.rd_req;
  assign w_unformed = (w_op != OP_FORM) && !r_formed[bus.addr];

  // Sequencer: state, counters, bitmap and every output are registered together.
  always_ff @(posedge clk or posedge CE) begin
    if (CE) begin
      r_state   <= IDLE;
      r_op      <= OP_FORM;
      r_formed  <= '0;
      r_addr    <= '0;
      r_wsh     <= '0;
      r_shadow  <= '0;
      r_rdata   <= '0;
      r_bit_cnt <= '0;
      r_tmr     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_ce      <= 1'b0;
      r_we      <= 1'b0;
      r_re      <= 1'b0;
      r_oe      <= 1'b0;
      r_dout    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any_req) begin
            r_op   <= w_op;
            r_addr <= bus.addr;
            r_wsh  <= bus.wdata;
            r_busy <= 1'b1;
            if (w_unformed) begin
              // Unformed cell: report failure without touching the array.
              r_state <= DONE;
              r_done  <= 1'b1;
              r_err   <= 1'b1;
            end else begin
              r_state <= SETUP;
              r_ce    <= 1'b1;
              r_tmr   <= '0;
            end
          end
        end
        SETUP: begin
          if (r_tmr == TW'(SETUP_CYC - 1)) begin
            r_tmr     <= '0;
            r_bit_cnt <= '0;
            case (r_op)
              OP_FORM: begin
                r_state <= FORM;
                r_we    <= 1'b1;
                r_oe    <= 1'b1;
                r_dout  <= 1'b1;
              end
              OP_WR: begin
                r_state <= WSHIFT;
                r_we    <= 1'b1;
                r_oe    <= 1'b1;
                r_dout  <= r_wsh[0];
                r_wsh   <= r_wsh >> 1;
              end
              default: begin
                r_state <= RSHIFT;
                r_re    <= 1'b1;
              end
            endcase
          end else begin
            r_tmr <= r_tmr + 1'b1;
          end
        end
        FORM: begin
          if (r_tmr == TW'(FORM_CYC - 1)) begin
            r_state          <= DONE;
            r_formed[r_addr] <= 1'b1;
            r_we             <= 1'b0;
            r_oe             <= 1'b0;
            r_dout           <= 1'b0;
            r_ce             <= 1'b0;
            r_done           <= 1'b1;
          end else begin
            r_tmr <= r_tmr + 1'b1;
          end
        end
        WSHIFT: begin
          if (r_bit_cnt == CW'(BITS - 1)) begin
            r_state <= DONE;
            r_we    <= 1'b0;
            r_oe    <= 1'b0;
            r_dout  <= 1'b0;
            r_ce    <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_bit_cnt <= r_bit_cnt + 1'b1;
            r_dout    <= r_wsh[0];
            r_wsh     <= r_wsh >> 1;
          end
        end
        RSHIFT: begin
          // Shift in from the top so the first bit read ends up in bit 0.
          r_shadow <= {bus.rram_din, r_shadow[BITS-1:1]};
          if (r_bit_cnt == CW'(BITS - 1)) begin
            r_state <= DONE;
            r_rdata <= {bus.rram_din, r_shadow[BITS-1:1]};
            r_re    <= 1'b0;
            r_ce    <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_bit_cnt <= r_bit_cnt + 1'b1;
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_done  <= 1'b0;
          r_err   <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.err       = r_err;
  assign bus.rdata     = r_rdata;
  assign bus.rram_ce   = r_ce;
  assign bus.rram_we   = r_we;
  assign bus.rram_re   = r_re;
  assign bus.rram_addr = r_addr;
  assign bus.rram_dout = r_dout;
  assign bus.rram_oe   = r_oe;

endmodule

// File: tb/tb_rram_seq_ctrl.sv
// Bench for rram_seq_ctrl: directed scenarios then random ops against a cycle-timeline model.
// Latency: model predicts every control output per cycle from the op type and the formed map.
// Backpressure: exercises dropped requests while busy and back-to-back held requests.
module tb_rram_seq_ctrl;
  localparam int SC = 2;
  localparam int FC = 8;
  localparam int BITS = 32;
  localparam int OP_FORM = 0, OP_WR = 1, OP_RD = 2, OP_ALL = 3;
  localparam int B2B = 2 * (SC + BITS) + 5;

  logic clk = 1'b0;
  logic CE  = 1'b1;
  always #5 clk = ~clk;

  rram_seq_ctrl_if #(.BITS(BITS)) bus();

  rram_seq_ctrl #(.SETUP_CYC(SC), .FORM_CYC(FC), .BITS(BITS)) dut (
    .clk(clk),
    .CE (CE),
    .bus(bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit formed[32];
  logic [BITS-1:0] exp_rdata = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // {busy,done,err,ce,we,re,oe}
  function automatic logic [6:0] ctl();
    return {bus.busy, bus.done, bus.err, bus.rram_ce, bus.rram_we, bus.rram_re, bus.rram_oe};
  endfunction

  task automatic clear_reqs();
    bus.form_req = 1'b0;
    bus.wr_req   = 1'b0;
    bus.rd_req   = 1'b0;
  endtask

  // Issue one op, follow its whole timeline cycle by cycle, then update the model.
  task automatic do_op(input int op, input logic [4:0] a, input logic [BITS-1:0] wd,
                       input logic [BITS-1:0] dw, input bit noise, input string tag);
    int eff, n, tot;
    bit e;
    logic [BITS-1:0] old_rd;
    logic [6:0] ev;
    bit dchk;
    logic dexp;
    eff    = (op == OP_ALL) ? OP_FORM : op;
    e      = (eff != OP_FORM) && !formed[a];
    n      = (eff == OP_FORM) ? FC : BITS;
    old_rd = exp_rdata;
    tot    = e ? 1 : SC + n + 1;
    @(negedge clk);
    bus.form_req = (op == OP_FORM) || (op == OP_ALL);
    bus.wr_req   = (op == OP_WR)   || (op == OP_ALL);
    bus.rd_req   = (op == OP_RD)   || (op == OP_ALL);
    bus.addr     = a;
    bus.wdata    = wd;
    @(negedge clk);
    clear_reqs();
    for (int k = 1; k <= tot + 2; k++) begin
      ev = '0; dchk = 0; dexp = 1'b0;
      if (e) begin
        if (k == 1) ev = 7'b1110000;
      end else if (k <= SC) begin
        ev = 7'b1001000;
      end else if (k <= SC + n) begin
        if (eff == OP_RD) ev = 7'b1001010;
        else begin
          ev   = 7'b1001101;
          dchk = 1;
          dexp = (eff == OP_FORM) ? 1'b1 : wd[k-SC-1];
        end
      end else if (k == SC + n + 1) begin
        ev = 7'b1100000;
      end
      chk({tag, "_ctl"}, 64'(ctl()), 64'(ev));
      if (dchk) chk({tag, "_dout"}, 64'(bus.rram_dout), 64'(dexp));
      if (ev[3]) chk({tag, "_addr"}, 64'(bus.rram_addr), 64'(a));
      if (k == tot) chk({tag, "_rdata"}, 64'(bus.rdata), 64'((!e && eff == OP_RD) ? dw : old_rd));
      bus.rram_din = (!e && eff == OP_RD && k > SC && k <= SC + n) ? dw[k-SC-1] : 1'b0;
      if (noise && !e && k >= 2 && k <= SC + n) begin
        bus.wr_req = 1'b1;
        bus.rd_req = 1'b1;
      end else begin
        clear_reqs();
      end
      if (k != tot + 2) @(negedge clk);
    end
    if (!e && eff == OP_FORM) formed[a] = 1'b1;
    if (!e && eff == OP_RD) exp_rdata = dw;
  endtask

  initial begin
    logic b_busy[B2B+1];
    logic b_done[B2B+1];
    int ndone;
    logic [BITS-1:0] wd;
    clear_reqs();
    bus.addr = '0;
    bus.wdata = '0;
    bus.rram_din = 1'b0;
    foreach (formed[i]) formed[i] = 1'b0;

    // Reset held: everything quiet.
    #3;
    chk("rst_ctl", 64'(ctl()), 64'd0);
    chk("rst_pins", 64'({bus.rram_dout, bus.rram_addr}), 64'd0);
    chk("rst_rdata", 64'(bus.rdata), 64'd0);
    repeat (2) @(negedge clk);
    CE = 1'b0;

    // Access to an unformed cell fails immediately.
    do_op(OP_RD, 5'd3, '0, 32'hFFFF_FFFF, 0, "rd_unformed");

    // Form, write known word, read it back.
    do_op(OP_FORM, 5'd0, '0, '0, 0, "form0");
    do_op(OP_WR, 5'd0, 32'h0000_5A93, '0, 0, "wr5a93");
    do_op(OP_RD, 5'd0, '0, 32'h0000_5A93, 0, "rd5a93");

    // All three requests at once: forming wins; extra requests while busy are dropped.
    do_op(OP_ALL, 5'd5, 32'h1234_5678, '0, 1, "prio");
    chk("drop_idle", 64'(ctl()), 64'd0);
    @(negedge clk);
    chk("drop_idle2", 64'(ctl()), 64'd0);

    // Reset pulse in the middle of a write, while bit 10 is on the pin.
    @(negedge clk);
    bus.wr_req = 1'b1; bus.addr = 5'd0; bus.wdata = 32'hFFFF_FBFF;
    @(negedge clk);
    clear_reqs();
    repeat (SC + 10) @(negedge clk);
    chk("abort_pre_we", 64'({bus.rram_we, bus.rram_dout}), 64'b10);
    #2 CE = 1'b1;
    #1;
    chk("abort_ctl", 64'(ctl()), 64'd0);
    chk("abort_pins", 64'({bus.rram_dout, bus.rram_addr}), 64'd0);
    chk("abort_rdata", 64'(bus.rdata), 64'd0);
    foreach (formed[i]) formed[i] = 1'b0;
    exp_rdata = '0;
    @(negedge clk);
    CE = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("abort_nodone", 64'({bus.busy, bus.done, bus.err}), 64'd0);
      @(negedge clk);
    end
    do_op(OP_WR, 5'd0, 32'hA5A5_A5A5, '0, 0, "wr_after_abort");

    // Held write request: second acceptance right after the one-cycle IDLE gap.
    do_op(OP_FORM, 5'd0, '0, '0, 0, "reform0");
    @(negedge clk);
    bus.wr_req = 1'b1; bus.addr = 5'd0; bus.wdata = 32'h0F0F_0F0F;
    ndone = 0;
    for (int k = 1; k <= B2B; k++) begin
      @(negedge clk);
      b_busy[k] = bus.busy;
      b_done[k] = bus.done;
      if (bus.done === 1'b1) ndone++;
      if (k == SC + BITS + 3) clear_reqs();
    end
    chk("b2b_done1", 64'(b_done[SC+BITS+1]), 64'd1);
    chk("b2b_gap", 64'(b_busy[SC+BITS+2]), 64'd0);
    chk("b2b_accept2", 64'(b_busy[SC+BITS+3]), 64'd1);
    chk("b2b_done2", 64'(b_done[2*(SC+BITS)+3]), 64'd1);
    chk("b2b_end", 64'(b_busy[B2B]), 64'd0);
    chk("b2b_ndone", 64'(ndone), 64'd2);

    // Random ops over a few addresses against the model.
    for (int t = 0; t < 16; t++) begin
      wd = $urandom;
      do_op(int'($urandom_range(0, 2)), 5'($urandom_range(0, 3)), wd, $urandom, 0, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
